// File: rtl/input_normalizer_if.sv
// input_normalizer_if: operand/result bundle between the normalizer and its neighbours.
//   inp_valid/inp_ready/inp : operand handshake into the normalizer
//   norm_out/k/out_err/out_valid : one-cycle result strobe towards CORDIC core and output scaler
//   master drives operands and observes results; slave is the normalizer itself
interface input_normalizer_if;
   logic               inp_valid;
   logic               inp_ready;
   logic signed [15:0] inp;
   logic signed [15:0] norm_out;
   logic        [2:0]  k;
   logic               out_err;
   logic               out_valid;
   modport master (output inp_valid, inp, input inp_ready, norm_out, k, out_err, out_valid);
   modport slave  (input inp_valid, inp, output inp_ready, norm_out, k, out_err, out_valid);
endinterface

// File: rtl/input_normalizer.sv
// input_normalizer: shifts a signed operand right by pairs of bits until it is below 2^MAX_W, counting pairs in k.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : input_normalizer_if.slave (inp_valid/inp_ready/inp in, norm_out/k/out_err/out_valid out)
//   MAX_W : normalized operand bound (1..15); KMAX : saturation limit for k (<= 7)
//   NORM_ROUND_EN : when defined, each 2-bit shift rounds half-up instead of truncating
module input_normalizer #(
   parameter int MAX_W = 12,
   parameter int KMAX  = 7
) (
   input logic               clk,
   input logic               reset,
   input_normalizer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t             state, state_n;
   logic signed [15:0] x, x_n, x_sh;
   logic        [2:0]  cnt, cnt_n;
   logic               err, err_n, fits;
   assign bus.inp_ready = (state == IDLE);
   // x is never negative here, so zero-extending gives an exact magnitude compare
   assign fits = {1'b0, x} < (17'd1 << MAX_W);
`ifdef NORM_ROUND_EN
   logic [15:0] x_rnd;
   assign x_rnd = 16'(x >>> 2) + {15'd0, x[1]};
   assign x_sh  = x_rnd[15] ? 16'sh7fff : signed'(x_rnd);
`else
   assign x_sh  = x >>> 2;
`endif
   always_comb begin
      state_n = state;
      x_n     = x;
      cnt_n   = cnt;
      err_n   = err;
      case (state)
         IDLE: if (bus.inp_valid) begin
            cnt_n   = 3'd0;
            x_n     = bus.inp[15] ? 16'sd0 : bus.inp;
            err_n   = bus.inp[15];
            state_n = bus.inp[15] ? DONE : SHIFT;
         end
         SHIFT: begin
            state_n = (fits || cnt == 3'(KMAX)) ? DONE : SHIFT;
            x_n     = (fits || cnt == 3'(KMAX)) ? x : x_sh;
            cnt_n   = (fits || cnt == 3'(KMAX)) ? cnt : cnt + 3'd1;
         end
         DONE: begin
            state_n = IDLE;
            err_n   = 1'b0;
         end
         default: state_n = IDLE;
      endcase
   end
   // Result registers load from next-state values so they are valid exactly while in DONE
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         x             <= '0;
         cnt           <= '0;
         err           <= 1'b0;
         bus.norm_out  <= '0;
         bus.k         <= '0;
         bus.out_err   <= 1'b0;
         bus.out_valid <= 1'b0;
      end else begin
         state         <= state_n;
         x             <= x_n;
         cnt           <= cnt_n;
         err           <= err_n;
         bus.norm_out  <= (state_n == DONE) ? x_n : 16'sd0;
         bus.k         <= (state_n == DONE) ? cnt_n : 3'd0;
         bus.out_err   <= (state_n == DONE) && err_n;
         bus.out_valid <= (state_n == DONE);
      end
   end
endmodule
